// File: rtl/mux_4to1_20bit_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux_4to1_20bit_arb_pkg
//
// Purpose: shared widths, output-stage state encoding and small helper types
// for the four-requester round-robin arbiter and its 20-bit datapath mux.
//
// Contents:
//   ARB_DATA_W   - width of every requester word and of the output word (20)
//   ARB_NUM_REQ  - number of requesters sharing the datapath (4)
//   ARB_IDX_W    - width of a requester index / mux select (2)
//   arb_state_e  - output register state, ARB_EMPTY = 0, ARB_FULL = 1
//   arbOneHot()  - turns a requester index into a one-hot grant vector
// ---------------------------------------------------------------------------
package mux_4to1_20bit_arb_pkg;

  localparam int ARB_DATA_W  = 20;
  localparam int ARB_NUM_REQ = 4;
  localparam int ARB_IDX_W   = 2;

  // The output register either holds a word nobody has taken yet or it does
  // not; Out_Valid is simply "state is FULL".
  typedef enum logic {
    ARB_EMPTY = 1'b0,
    ARB_FULL  = 1'b1
  } arb_state_e;

  typedef logic [ARB_DATA_W-1:0]  arb_data_t;
  typedef logic [ARB_IDX_W-1:0]   arb_idx_t;
  typedef logic [ARB_NUM_REQ-1:0] arb_req_t;

  // Builds the one-hot grant for a winner index. Written as a bit set rather
  // than a shift so the result width is obviously ARB_NUM_REQ.
  function automatic arb_req_t arbOneHot(input arb_idx_t idx);
    arb_req_t oneHot;
    oneHot      = '0;
    oneHot[idx] = 1'b1;
    return oneHot;
  endfunction

endpackage

// File: rtl/mux_4to1_20bit.sv
// ---------------------------------------------------------------------------
// mux_4to1_20bit
//
// Purpose: plain combinational 4:1 multiplexer for 20-bit words. This is the
// shared datapath that the arbiter steers with its Select output.
//
// Ports:
//   In0..In3 (in,  20) - candidate words
//   Select   (in,   2) - index of the word to pass through
//   Out      (out, 20) - the selected word
// ---------------------------------------------------------------------------
module mux_4to1_20bit
  import mux_4to1_20bit_arb_pkg::*;
(
  input  logic [ARB_DATA_W-1:0] In0,
  input  logic [ARB_DATA_W-1:0] In1,
  input  logic [ARB_DATA_W-1:0] In2,
  input  logic [ARB_DATA_W-1:0] In3,
  input  logic [ARB_IDX_W-1:0]  Select,
  output logic [ARB_DATA_W-1:0] Out
);

  // Straight selection; every select value is covered so no latch is implied.
  always_comb begin
    Out = In0;
    case (Select)
      2'd0:    Out = In0;
      2'd1:    Out = In1;
      2'd2:    Out = In2;
      default: Out = In3;
    endcase
  end

endmodule

// File: rtl/mux_4to1_20bit_arb.sv
// ---------------------------------------------------------------------------
// mux_4to1_20bit_arb
//
// Purpose: arbitrates four 20-bit producers onto one shared mux_4to1_20bit
// datapath and presents the chosen word to a single consumer through a
// one-entry output register with a valid/ready handshake. The register can
// drain and refill on the same edge, so a continuously ready consumer sees
// one word per cycle.
//
// Parameters:
//   RR_ENABLE - 1: round-robin starting after the last winner
//               0: fixed priority, requester 0 highest
//
// Ports:
//   Clock     (in,   1) - sole clock, rising edge
//   Reset_n   (in,   1) - synchronous active-low reset
//   Req       (in,   4) - Req[i] high: In<i> holds a valid word
//   In0..In3  (in,  20) - requester words
//   Gnt       (out,  4) - one-hot, Gnt[i]: In<i> is consumed at this edge
//   Select    (out,  2) - mux select, the current winner index
//   Out       (out, 20) - registered output word
//   Out_Valid (out,  1) - Out holds a word not yet accepted
//   Out_Ready (in,   1) - consumer takes Out this edge when Out_Valid is high
// ---------------------------------------------------------------------------
module mux_4to1_20bit_arb
  import mux_4to1_20bit_arb_pkg::*;
#(
  parameter bit RR_ENABLE = 1'b1
)
(
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic [ARB_NUM_REQ-1:0] Req,
  input  logic [ARB_DATA_W-1:0]  In0,
  input  logic [ARB_DATA_W-1:0]  In1,
  input  logic [ARB_DATA_W-1:0]  In2,
  input  logic [ARB_DATA_W-1:0]  In3,
  output logic [ARB_NUM_REQ-1:0] Gnt,
  output logic [ARB_IDX_W-1:0]   Select,
  output logic [ARB_DATA_W-1:0]  Out,
  output logic                   Out_Valid,
  input  logic                   Out_Ready
);

  // Picks the winner among the pending requesters.
  // Round-robin: rotate the scan so it starts just after the last winner and
  // take the first pending index. The loop walks the offsets from the far end
  // back towards last+1 so the nearest pending requester is assigned last and
  // therefore wins. Offset ARB_NUM_REQ wraps to the last winner itself, which
  // lets a lone requester win back-to-back.
  // Fixed priority: same trick, scanning down so index 0 is assigned last.
  // With no request pending the result is 0, which is also the idle Select.
  function automatic arb_idx_t pickWinner(input arb_req_t req,
                                          input arb_idx_t last,
                                          input bit       roundRobin);
    arb_idx_t winner;
    arb_idx_t idx;
    winner = '0;
    if (roundRobin) begin
      for (int k = ARB_NUM_REQ; k >= 1; k--) begin
        idx = last + arb_idx_t'(k);
        if (req[idx]) begin
          winner = idx;
        end
      end
    end else begin
      for (int k = ARB_NUM_REQ - 1; k >= 0; k--) begin
        if (req[k]) begin
          winner = arb_idx_t'(k);
        end
      end
    end
    return winner;
  endfunction

  arb_state_e r_state;
  arb_state_e w_stateNext;
  arb_data_t  r_out;
  arb_idx_t   r_last;

  logic      w_anyReq;
  logic      w_load;
  arb_idx_t  w_winner;
  arb_idx_t  w_select;
  arb_data_t w_muxOut;

  // Winner, select and load are all combinational from Req, the stored
  // pointer and Out_Ready. Reset_n gates load and select so that a reset
  // cycle never hands out a grant and the mux sits at index 0.
  always_comb begin
    w_anyReq = |Req;
    w_winner = pickWinner(Req, r_last, RR_ENABLE);
    w_load   = Reset_n && w_anyReq && ((r_state == ARB_EMPTY) || Out_Ready);
    w_select = (Reset_n && w_anyReq) ? w_winner : '0;
  end

  assign Select    = w_select;
  assign Gnt       = w_load ? arbOneHot(w_winner) : '0;
  assign Out       = r_out;
  assign Out_Valid = (r_state == ARB_FULL);

  // Shared datapath: the select follows the winner, so on a load edge the
  // mux output is exactly the word being granted.
  mux_4to1_20bit u_mux (
    .In0    (In0),
    .In1    (In1),
    .In2    (In2),
    .In3    (In3),
    .Select (w_select),
    .Out    (w_muxOut)
  );

  // Output FSM next state. A load always leaves us FULL, which covers the
  // drain-and-refill case; only an accepted word with nothing to replace it
  // empties the register.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ARB_EMPTY: begin
        if (w_load) begin
          w_stateNext = ARB_FULL;
        end
      end
      ARB_FULL: begin
        if (w_load) begin
          w_stateNext = ARB_FULL;
        end else if (Out_Ready) begin
          w_stateNext = ARB_EMPTY;
        end
      end
      default: w_stateNext = ARB_EMPTY;
    endcase
  end

  // State, data and pointer registers. The pointer resets to 3 so the first
  // round-robin scan starts at requester 0. Out only changes on a load, so a
  // stalled or drained register keeps its word and there is no combinational
  // path from Out_Ready to Out.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_state <= ARB_EMPTY;
      r_out   <= '0;
      r_last  <= 2'b11;
    end else begin
      r_state <= w_stateNext;
      if (w_load) begin
        r_out  <= w_muxOut;
        r_last <= w_winner;
      end
    end
  end

  // Design invariants: never more than one grant, and a stalled word stays
  // put until the consumer takes it.
  assert property (@(posedge Clock) disable iff (!Reset_n) $onehot0(Gnt));
  assert property (@(posedge Clock) disable iff (!Reset_n)
                   (Out_Valid && !Out_Ready) |=> (Out_Valid && $stable(Out)));

endmodule

// File: tb/tb_mux_4to1_20bit_arb.sv
// ---------------------------------------------------------------------------
// tb_mux_4to1_20bit_arb
//
// Purpose: self-checking bench for mux_4to1_20bit_arb. A round-robin instance
// is driven through directed scenarios and a randomized phase; a behavioural
// model predicts grants and pushes expected words into a scoreboard queue,
// and an independent monitor pops and compares every accepted output word.
// A second instance with RR_ENABLE = 0 checks fixed priority.
// ---------------------------------------------------------------------------
module tb_mux_4to1_20bit_arb;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic [3:0]  req = 4'h0;
  logic [19:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic        outReady = 1'b0;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic [19:0] out;
  logic        outValid;

  logic [3:0]  fpReq = 4'h0;
  logic [19:0] fpIn0 = '0, fpIn1 = '0, fpIn2 = '0, fpIn3 = '0;
  logic        fpReady = 1'b1;
  logic [3:0]  fpGnt;
  logic [1:0]  fpSel;
  logic [19:0] fpOut;
  logic        fpValid;

  int checks = 0;
  int failures = 0;

  // Behavioural model: output register full flag, held word, last winner,
  // and the queue of words the consumer is still owed.
  bit          mFull = 1'b0;
  logic [19:0] mOut = '0;
  int          mLast = 3;
  logic [19:0] expQ[$];

  always #5 Clock = ~Clock;

  mux_4to1_20bit_arb #(.RR_ENABLE(1'b1)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Req(req),
    .In0(in0), .In1(in1), .In2(in2), .In3(in3),
    .Gnt(gnt), .Select(sel), .Out(out), .Out_Valid(outValid),
    .Out_Ready(outReady)
  );

  mux_4to1_20bit_arb #(.RR_ENABLE(1'b0)) dutFp (
    .Clock(Clock), .Reset_n(Reset_n), .Req(fpReq),
    .In0(fpIn0), .In1(fpIn1), .In2(fpIn2), .In3(fpIn3),
    .Gnt(fpGnt), .Select(fpSel), .Out(fpOut), .Out_Valid(fpValid),
    .Out_Ready(fpReady)
  );

  // One comparison: count it, and report it if it does not match.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Round-robin: first pending index scanning last+1, last+2, ... mod 4.
  // Fixed priority: lowest pending index. -1 when nobody is requesting.
  function automatic int modelWinner(input logic [3:0] r, input int last,
                                     input bit rr);
    if (rr) begin
      for (int k = 1; k <= 4; k++) begin
        int idx;
        idx = (last + k) % 4;
        if (r[idx]) return idx;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r[i]) return i;
      end
    end
    return -1;
  endfunction

  // One clock cycle on the round-robin instance: drive inputs just after the
  // rising edge, then at the falling edge compare the registered outputs
  // against the model and the combinational grant/select against the model's
  // decision for this cycle, then advance the model across the next edge.
  task automatic applyStimulus(input logic rstn, input logic [3:0] r,
                               input logic [19:0] d0, input logic [19:0] d1,
                               input logic [19:0] d2, input logic [19:0] d3,
                               input logic rdy,
                               output logic [3:0] expGnt,
                               output logic [1:0] gotSel);
    logic [19:0] words[4];
    int          win;
    bit          load;
    logic [1:0]  expSel;
    @(posedge Clock);
    #1;
    Reset_n = rstn; req = r; outReady = rdy;
    in0 = d0; in1 = d1; in2 = d2; in3 = d3;
    words[0] = d0; words[1] = d1; words[2] = d2; words[3] = d3;
    @(negedge Clock);
    checkOutput("out_valid", {31'b0, outValid}, {31'b0, mFull});
    checkOutput("out", {12'b0, out}, {12'b0, mOut});
    expGnt = 4'b0000;
    expSel = 2'b00;
    load   = 1'b0;
    win    = -1;
    if (rstn) begin
      win  = modelWinner(r, mLast, 1'b1);
      load = (win >= 0) && (!mFull || rdy);
      if (win >= 0) expSel = 2'(win);
      if (load) expGnt[win] = 1'b1;
    end
    checkOutput("gnt", {28'b0, gnt}, {28'b0, expGnt});
    checkOutput("select", {30'b0, sel}, {30'b0, expSel});
    gotSel = sel;
    if (!rstn) begin
      mFull = 1'b0;
      mOut  = '0;
      mLast = 3;
      expQ.delete();
    end else if (load) begin
      expQ.push_back(words[win]);
      mOut  = words[win];
      mLast = win;
      mFull = 1'b1;
    end else if (mFull && rdy) begin
      mFull = 1'b0;
    end
  endtask

  // Monitor: every accepted word must be the oldest one the model promised.
  always @(negedge Clock) begin
    if (Reset_n && outValid && outReady) begin
      if (expQ.size() == 0) begin
        failures++;
        checks++;
        $display("[TB] FAIL scoreboard_empty: got %h expected no word", out);
      end else begin
        checkOutput("scoreboard_out", {12'b0, out}, {12'b0, expQ.pop_front()});
      end
    end
  end

  initial begin : main
    logic [3:0]  g;
    logic [1:0]  s;
    logic [3:0]  fairGnt[5];
    bit          pending[4];
    logic [19:0] pendData[4];
    logic [19:0] fpPrev;

    fairGnt[0] = 4'b0001; fairGnt[1] = 4'b0010; fairGnt[2] = 4'b0100;
    fairGnt[3] = 4'b1000; fairGnt[4] = 4'b0001;

    // Reset held with every requester asking: no grants, empty, zero.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'hF, 20'h00001, 20'h00002, 20'h00003, 20'h00004,
                    1'b1, g, s);
      checkOutput("reset_gnt", {28'b0, gnt}, 32'h0);
    end

    // Fairness: all four requesting, consumer always ready.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'hF, 20'h00001, 20'h00002, 20'h00003, 20'h00004,
                    1'b1, g, s);
      checkOutput("fair_gnt", {28'b0, gnt}, {28'b0, fairGnt[i]});
      checkOutput("fair_select", {30'b0, s}, i % 4);
    end

    // Drain, then back-pressure with only requester 2 asking.
    applyStimulus(1'b1, 4'h0, '0, '0, '0, '0, 1'b1, g, s);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'b0100, '0, '0, 20'hABCDE, '0, 1'b0, g, s);
      checkOutput("bp_gnt", {28'b0, gnt}, (i == 0) ? 32'h4 : 32'h0);
    end
    checkOutput("bp_out", {12'b0, out}, 32'hABCDE);
    applyStimulus(1'b1, 4'b0100, '0, '0, 20'h12345, '0, 1'b1, g, s);
    checkOutput("bp_reload_gnt", {28'b0, gnt}, 32'h4);

    // Pointer wrap: grant 3, then 0 and 3 contend.
    applyStimulus(1'b1, 4'b1000, '0, '0, '0, 20'h33333, 1'b1, g, s);
    checkOutput("wrap_gnt3", {28'b0, gnt}, 32'h8);
    applyStimulus(1'b1, 4'b1001, 20'h00AAA, '0, '0, 20'h33334, 1'b1, g, s);
    checkOutput("wrap_gnt0", {28'b0, gnt}, 32'h1);
    applyStimulus(1'b1, 4'b1000, '0, '0, '0, 20'h33334, 1'b1, g, s);
    checkOutput("wrap_gnt3b", {28'b0, gnt}, 32'h8);

    // Mid-stream reset while holding 20'hFFFFF.
    applyStimulus(1'b1, 4'b0001, 20'hFFFFF, '0, '0, '0, 1'b1, g, s);
    applyStimulus(1'b0, 4'hF, 20'h1, 20'h2, 20'h3, 20'h4, 1'b0, g, s);
    checkOutput("mid_reset_gnt", {28'b0, gnt}, 32'h0);
    applyStimulus(1'b1, 4'hF, 20'h1, 20'h2, 20'h3, 20'h4, 1'b1, g, s);
    checkOutput("mid_reset_out", {12'b0, out}, 32'h0);
    checkOutput("mid_reset_gnt0", {28'b0, gnt}, 32'h1);

    // Fixed priority on the second instance: 1 always beats 2 and 3.
    fpPrev = 20'(($urandom % 20'hFFFFF) + 1);
    fpIn1 = fpPrev; fpIn2 = 20'h22222; fpIn3 = 20'h33333;
    fpReq = 4'b1110; fpReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'h0, '0, '0, '0, '0, 1'b1, g, s);
      checkOutput("fp_gnt", {28'b0, fpGnt}, 32'h2);
      checkOutput("fp_select", {30'b0, fpSel}, 32'h1);
      checkOutput("fp_out", {12'b0, fpOut}, {12'b0, fpPrev});
      checkOutput("fp_valid", {31'b0, fpValid}, 32'h1);
      fpPrev = 20'($urandom);
      fpIn1  = fpPrev;
    end
    fpReq = 4'h0;

    // Random traffic obeying the requester rule, with occasional resets.
    for (int i = 0; i < 4; i++) begin
      pending[i]  = 1'b0;
      pendData[i] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      logic [3:0] r;
      logic       rstn;
      for (int i = 0; i < 4; i++) begin
        if (!pending[i] && $urandom_range(0, 2) == 0) begin
          pending[i]  = 1'b1;
          pendData[i] = 20'($urandom);
        end
      end
      r    = {pending[3], pending[2], pending[1], pending[0]};
      rstn = ($urandom_range(0, 49) != 0);
      applyStimulus(rstn, r, pendData[0], pendData[1], pendData[2],
                    pendData[3], 1'($urandom_range(0, 1)), g, s);
      for (int i = 0; i < 4; i++) begin
        if (g[i]) pending[i] = 1'b0;
      end
    end

    // Let the last word drain so the monitor sees it.
    applyStimulus(1'b1, 4'h0, '0, '0, '0, '0, 1'b1, g, s);
    applyStimulus(1'b1, 4'h0, '0, '0, '0, '0, 1'b1, g, s);
    checkOutput("final_queue_empty", expQ.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
